// File: rtl/match_chunk_scheduler_if.sv
// Bus between the chunk scheduler and its environment (host control + matcher groups).
// master: the scheduler side (drives dispatch, status and merged results).
// slave : the host / matcher-group side (drives start, length, completions and hit flags).
interface match_chunk_scheduler_if #(
    parameter int unsigned GROUPS    = 16,
    parameter int unsigned CHUNK_LEN = 64,
    parameter int unsigned LEN_W     = 16
);
    localparam int unsigned CLW = $clog2(CHUNK_LEN + 1);

    logic              start;
    logic [LEN_W-1:0]  total_len;
    logic [GROUPS-1:0] grp_go;
    logic [LEN_W-1:0]  chunk_base;
    logic [CLW-1:0]    chunk_len;
    logic [GROUPS-1:0] grp_done;
    logic [GROUPS-1:0] grp_hit;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  hit_count;
    logic [LEN_W-1:0]  first_hit_base;
    logic              err_spurious;

    modport master (
        input  start, total_len, grp_done, grp_hit,
        output grp_go, chunk_base, chunk_len, busy, done, hit_count, first_hit_base, err_spurious
    );

    modport slave (
        output start, total_len, grp_done, grp_hit,
        input  grp_go, chunk_base, chunk_len, busy, done, hit_count, first_hit_base, err_spurious
    );
endinterface

// File: rtl/match_chunk_scheduler.sv
// Splits a string of total_len bytes into overlapping CHUNK_LEN windows (stride
// CHUNK_LEN-WEIGHT_MAX_LENGTH+1), dispatches them round-robin to idle matcher groups, tracks
// per-group completion and merges hit flags into a hit count and the lowest hitting chunk base.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   bus (master)   start/total_len in; grp_go/chunk_base/chunk_len dispatch out;
//                  grp_done/grp_hit completions in; busy/done/hit_count/first_hit_base/
//                  err_spurious status out (all outputs registered)
module match_chunk_scheduler #(
    parameter int unsigned GROUPS            = 16,
    parameter int unsigned CHUNK_LEN         = 64,
    parameter int unsigned WEIGHT_MAX_LENGTH = 32,
    parameter int unsigned LEN_W             = 16
) (
    input logic                    clk,
    input logic                    reset,
    match_chunk_scheduler_if.master bus
);
    localparam int unsigned STRIDE = CHUNK_LEN - WEIGHT_MAX_LENGTH + 1;
    localparam int unsigned CLW    = $clog2(CHUNK_LEN + 1);
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    // One extra bit so base + CHUNK_LEN never wraps.
    localparam int unsigned EW     = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     len_q, len_d;
    logic [EW-1:0]     nbase_q, nbase_d;
    logic [GW-1:0]     rr_q, rr_d;
    logic [GROUPS-1:0] gbusy_q, gbusy_d;
    logic [LEN_W-1:0]  base_mem_q [GROUPS];
    logic [GROUPS-1:0] go_q, go_d;
    logic [LEN_W-1:0]  cbase_q, cbase_d;
    logic [CLW-1:0]    clen_q, clen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  hcnt_q, hcnt_d;
    logic [LEN_W-1:0]  fhb_q, fhb_d;
    logic              err_q, err_d;

    logic [GROUPS-1:0] hits_c;
    logic              spur_c;
    logic [EW-1:0]     pop_c;
    logic [EW-1:0]     sum_c;
    logic              found_c;
    logic [GW-1:0]     pick_c;
    logic [GW-1:0]     cand_c;
    logic [EW-1:0]     remain_c;
    logic              disp_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, dispatch selection and result merging.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        nbase_d  = nbase_q;
        rr_d     = rr_q;
        go_d     = '0;
        cbase_d  = cbase_q;
        clen_d   = clen_q;
        done_d   = 1'b0;
        disp_c   = 1'b0;
        found_c  = 1'b0;
        pick_c   = '0;
        cand_c   = '0;
        remain_c = '0;
        pop_c    = '0;

        // Only completions from groups that are actually out count as hits.
        hits_c = bus.grp_done & bus.grp_hit & gbusy_q;
        spur_c = |(bus.grp_done & ~gbusy_q);

        fhb_d = fhb_q;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            if (hits_c[g]) begin
                pop_c = pop_c + EW'(1);
                if (base_mem_q[g] < fhb_d) begin
                    fhb_d = base_mem_q[g];
                end
            end
        end
        sum_c  = EW'(hcnt_q) + pop_c;
        hcnt_d = sum_c[LEN_W] ? '1 : sum_c[LEN_W-1:0];
        err_d  = err_q | spur_c;

        // First idle group at/after the round-robin pointer, using registered busy bits.
        for (int unsigned i = 0; i < GROUPS; i++) begin
            cand_c = GW'((32'(rr_q) + 32'(i)) % GROUPS);
            if (!found_c && !gbusy_q[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = EW'(bus.total_len);
                    nbase_d = '0;
                    hcnt_d  = '0;
                    fhb_d   = '1;
                    err_d   = spur_c;
                    state_d = (bus.total_len == '0) ? ST_FINISH : ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (found_c) begin
                    disp_c   = 1'b1;
                    remain_c = len_q - nbase_q;
                    go_d     = GROUPS'(1) << pick_c;
                    cbase_d  = nbase_q[LEN_W-1:0];
                    clen_d   = (remain_c >= EW'(CHUNK_LEN)) ? CLW'(CHUNK_LEN) : CLW'(remain_c);
                    rr_d     = GW'((32'(pick_c) + 32'd1) % GROUPS);
                    nbase_d  = nbase_q + EW'(STRIDE);
                    if (nbase_q + EW'(CHUNK_LEN) >= len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (gbusy_q == '0) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        gbusy_d = (gbusy_q & ~bus.grp_done) | go_d;
        busy_d  = (state_d != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= '0;
            nbase_q <= '0;
            rr_q    <= '0;
            gbusy_q <= '0;
            go_q    <= '0;
            cbase_q <= '0;
            clen_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hcnt_q  <= '0;
            fhb_q   <= '1;
            err_q   <= 1'b0;
            for (int unsigned g = 0; g < GROUPS; g++) begin
                base_mem_q[g] <= '0;
            end
        end else begin
            len_q   <= len_d;
            nbase_q <= nbase_d;
            rr_q    <= rr_d;
            gbusy_q <= gbusy_d;
            go_q    <= go_d;
            cbase_q <= cbase_d;
            clen_q  <= clen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hcnt_q  <= hcnt_d;
            fhb_q   <= fhb_d;
            err_q   <= err_d;
            if (disp_c) begin
                base_mem_q[pick_c] <= nbase_q[LEN_W-1:0];
            end
        end
    end

    assign bus.grp_go         = go_q;
    assign bus.chunk_base     = cbase_q;
    assign bus.chunk_len      = clen_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.hit_count      = hcnt_q;
    assign bus.first_hit_base = fhb_q;
    assign bus.err_spurious   = err_q;
endmodule

// File: tb/tb_match_chunk_scheduler.sv
// Directed bench for match_chunk_scheduler: a 16-group and a 2-group instance share clock and
// reset. Expected dispatches are pushed to per-instance queues when a job starts and popped
// when grp_go appears; a built-in responder returns grp_done/grp_hit after a per-group latency.
module tb_match_chunk_scheduler;
    localparam int CHUNK  = 64;
    localparam int STRIDE = 64 - 32 + 1;

    typedef struct {
        int grp;
        int base;
        int len;
    } exp_t;

    logic clk;
    logic reset;

    match_chunk_scheduler_if #(.GROUPS(16), .CHUNK_LEN(64), .LEN_W(16)) bus16 ();
    match_chunk_scheduler_if #(.GROUPS(2),  .CHUNK_LEN(64), .LEN_W(16)) bus2 ();

    match_chunk_scheduler #(.GROUPS(16), .CHUNK_LEN(64), .WEIGHT_MAX_LENGTH(32), .LEN_W(16)) u16 (
        .clk(clk), .reset(reset), .bus(bus16.master)
    );
    match_chunk_scheduler #(.GROUPS(2), .CHUNK_LEN(64), .WEIGHT_MAX_LENGTH(32), .LEN_W(16)) u2 (
        .clk(clk), .reset(reset), .bus(bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    int   done_cnt16 = 0;
    int   done_cnt2 = 0;
    exp_t q16[$];
    exp_t q2[$];
    int   stamp16[$];
    int   stamp2[$];
    int   tmr[2][16];
    int   lat[2][16];
    logic hitcfg[2][16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference chunking: bases step by STRIDE, last chunk when base+CHUNK >= total.
    task automatic push_chunks(input int inst, input int total, input int grp0, input int ng);
        exp_t e;
        int   base;
        base = 0;
        if (total == 0) return;
        for (int k = 0; k < 4096; k++) begin
            e.grp  = (grp0 + k) % ng;
            e.base = base;
            e.len  = (total - base < CHUNK) ? total - base : CHUNK;
            if (inst == 0) q16.push_back(e);
            else           q2.push_back(e);
            if (base + CHUNK >= total) break;
            base = base + STRIDE;
        end
    endtask

    // One clock: sample outputs after the edge, score dispatches, drive completions.
    task automatic cyc();
        exp_t e;
        int   gi;
        @(posedge clk);
        #1;
        cyc_n++;
        bus16.start = 1'b0; bus16.grp_done = '0; bus16.grp_hit = '0;
        bus2.start  = 1'b0; bus2.grp_done  = '0; bus2.grp_hit  = '0;
        if (bus16.done) done_cnt16++;
        if (bus2.done)  done_cnt2++;
        if (bus16.grp_go != '0) begin
            gi = -1;
            for (int g = 0; g < 16; g++) if (bus16.grp_go[g]) gi = g;
            stamp16.push_back(cyc_n);
            if (q16.size() == 0) begin
                chk("u16_go_unexpected", 64'(bus16.grp_go), 64'd0);
            end else begin
                e = q16.pop_front();
                chk("u16_go_grp", 64'(bus16.grp_go), 64'(1) << e.grp);
                chk("u16_go_base", 64'(bus16.chunk_base), 64'(e.base));
                chk("u16_go_len", 64'(bus16.chunk_len), 64'(e.len));
            end
            if (gi >= 0) tmr[0][gi] = lat[0][gi];
        end
        if (bus2.grp_go != '0) begin
            gi = -1;
            for (int g = 0; g < 2; g++) if (bus2.grp_go[g]) gi = g;
            stamp2.push_back(cyc_n);
            if (q2.size() == 0) begin
                chk("u2_go_unexpected", 64'(bus2.grp_go), 64'd0);
            end else begin
                e = q2.pop_front();
                chk("u2_go_grp", 64'(bus2.grp_go), 64'(1) << e.grp);
                chk("u2_go_base", 64'(bus2.chunk_base), 64'(e.base));
                chk("u2_go_len", 64'(bus2.chunk_len), 64'(e.len));
            end
            if (gi >= 0) tmr[1][gi] = lat[1][gi];
        end
        for (int g = 0; g < 16; g++) begin
            if (tmr[0][g] > 0) begin
                tmr[0][g]--;
                if (tmr[0][g] == 0) begin
                    bus16.grp_done[g] = 1'b1;
                    bus16.grp_hit[g]  = hitcfg[0][g];
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            if (tmr[1][g] > 0) begin
                tmr[1][g]--;
                if (tmr[1][g] == 0) begin
                    bus2.grp_done[g] = 1'b1;
                    bus2.grp_hit[g]  = hitcfg[1][g];
                end
            end
        end
    endtask

    task automatic wait_done(input int inst, input int budget, input string tag);
        int c0;
        bit got;
        c0  = (inst == 0) ? done_cnt16 : done_cnt2;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            cyc();
            got = (((inst == 0) ? done_cnt16 : done_cnt2) != c0);
        end
        chk(tag, 64'(got), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    function automatic int outstanding(input int inst);
        int n;
        n = 0;
        for (int g = 0; g < 16; g++) if (tmr[inst][g] > 0) n++;
        return n;
    endfunction

    task automatic chk_rst2();
        chk("rst2_go", 64'(bus2.grp_go), 64'd0);
        chk("rst2_base", 64'(bus2.chunk_base), 64'd0);
        chk("rst2_len", 64'(bus2.chunk_len), 64'd0);
        chk("rst2_busy", 64'(bus2.busy), 64'd0);
        chk("rst2_done", 64'(bus2.done), 64'd0);
        chk("rst2_hc", 64'(bus2.hit_count), 64'd0);
        chk("rst2_fhb", 64'(bus2.first_hit_base), 64'hFFFF);
        chk("rst2_err", 64'(bus2.err_spurious), 64'd0);
    endtask

    task automatic run_t2(input string p);
        int s;
        int d0;
        stamp2.delete();
        for (int g = 0; g < 2; g++) begin lat[1][g] = 5; hitcfg[1][g] = 1'b0; end
        push_chunks(1, 200, 0, 2);
        bus2.total_len = 16'd200;
        bus2.start     = 1'b1;
        s  = cyc_n;
        d0 = done_cnt2;
        wait_done(1, 200, {p, "_done"});
        chk({p, "_q_empty"}, 64'(q2.size()), 64'd0);
        chk({p, "_outstanding"}, 64'(outstanding(1)), 64'd0);
        chk({p, "_ndisp"}, 64'(stamp2.size()), 64'd6);
        if (stamp2.size() >= 3) begin
            chk({p, "_first_go"}, 64'(stamp2[0] - s), 64'd2);
            chk({p, "_second_go"}, 64'(stamp2[1] - stamp2[0]), 64'd1);
            chk({p, "_stall"}, 64'(stamp2[2] - stamp2[0]), 64'd6);
        end
        chk({p, "_one_done"}, 64'(done_cnt2 - d0), 64'd1);
        chk({p, "_busy"}, 64'(bus2.busy), 64'd0);
        chk({p, "_hc"}, 64'(bus2.hit_count), 64'd0);
        chk({p, "_fhb"}, 64'(bus2.first_hit_base), 64'hFFFF);
    endtask

    task automatic run_t4(input string p, input int l1, input int l2);
        for (int g = 0; g < 16; g++) begin lat[0][g] = 3; hitcfg[0][g] = 1'b0; end
        lat[0][1] = l1; lat[0][2] = l2;
        hitcfg[0][1] = 1'b1; hitcfg[0][2] = 1'b1;
        push_chunks(0, 100, 0, 16);
        bus16.total_len = 16'd100;
        bus16.start     = 1'b1;
        wait_done(0, 60, {p, "_done"});
        chk({p, "_hc"}, 64'(bus16.hit_count), 64'd2);
        chk({p, "_fhb"}, 64'(bus16.first_hit_base), 64'd33);
        chk({p, "_q_empty"}, 64'(q16.size()), 64'd0);
    endtask

    initial begin
        int s;
        int d0;
        reset = 1'b1;
        bus16.start = 1'b0; bus16.total_len = '0; bus16.grp_done = '0; bus16.grp_hit = '0;
        bus2.start  = 1'b0; bus2.total_len  = '0; bus2.grp_done  = '0; bus2.grp_hit  = '0;
        for (int i = 0; i < 2; i++) begin
            for (int g = 0; g < 16; g++) begin
                tmr[i][g] = 0; lat[i][g] = 3; hitcfg[i][g] = 1'b0;
            end
        end
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst16_go", 64'(bus16.grp_go), 64'd0);
        chk("rst16_busy", 64'(bus16.busy), 64'd0);
        chk("rst16_done", 64'(bus16.done), 64'd0);
        chk("rst16_hc", 64'(bus16.hit_count), 64'd0);
        chk("rst16_fhb", 64'(bus16.first_hit_base), 64'hFFFF);
        chk("rst16_err", 64'(bus16.err_spurious), 64'd0);
        chk_rst2();

        // T1: three back-to-back dispatches on 16 groups, no hits.
        lat[0][0] = 4; lat[0][1] = 3; lat[0][2] = 2;
        stamp16.delete();
        push_chunks(0, 100, 0, 16);
        bus16.total_len = 16'd100;
        bus16.start     = 1'b1;
        s = cyc_n;
        cyc();
        chk("t1_no_go_at_start_edge", 64'(bus16.grp_go), 64'd0);
        chk("t1_busy", 64'(bus16.busy), 64'd1);
        wait_done(0, 60, "t1_done");
        chk("t1_q_empty", 64'(q16.size()), 64'd0);
        chk("t1_ndisp", 64'(stamp16.size()), 64'd3);
        if (stamp16.size() == 3) begin
            chk("t1_first_go", 64'(stamp16[0] - s), 64'd2);
            chk("t1_consec", 64'(stamp16[2] - stamp16[0]), 64'd2);
        end
        chk("t1_hc", 64'(bus16.hit_count), 64'd0);
        chk("t1_fhb", 64'(bus16.first_hit_base), 64'hFFFF);
        cyc();
        chk("t1_done_one_cycle", 64'(bus16.done), 64'd0);

        // T2: two groups, stalls until a group frees up.
        run_t2("t2");

        // T3: zero-length job.
        bus16.total_len = 16'd0;
        bus16.start     = 1'b1;
        cyc();
        chk("t3_done_early", 64'(bus16.done), 64'd0);
        chk("t3_busy", 64'(bus16.busy), 64'd1);
        cyc();
        chk("t3_done", 64'(bus16.done), 64'd1);
        chk("t3_busy_end", 64'(bus16.busy), 64'd0);
        chk("t3_hc", 64'(bus16.hit_count), 64'd0);
        chk("t3_fhb", 64'(bus16.first_hit_base), 64'hFFFF);

        // T4: hits out of base order, then in the same cycle.
        do_reset();
        run_t4("t4a", 8, 2);
        do_reset();
        run_t4("t4b", 6, 5);

        // T5: spurious completion while idle; start while busy is ignored.
        for (int g = 0; g < 16; g++) begin lat[0][g] = 3; hitcfg[0][g] = 1'b0; end
        chk("t5_err_before", 64'(bus16.err_spurious), 64'd0);
        bus16.grp_done[5] = 1'b1;
        cyc();
        chk("t5_err_set", 64'(bus16.err_spurious), 64'd1);
        cyc(); cyc(); cyc();
        chk("t5_err_sticky", 64'(bus16.err_spurious), 64'd1);
        chk("t5_hc_hold", 64'(bus16.hit_count), 64'd2);
        chk("t5_fhb_hold", 64'(bus16.first_hit_base), 64'd33);
        push_chunks(0, 100, 3, 16);
        bus16.total_len = 16'd100;
        bus16.start     = 1'b1;
        d0 = done_cnt16;
        cyc();
        chk("t5_err_cleared", 64'(bus16.err_spurious), 64'd0);
        chk("t5_hc_cleared", 64'(bus16.hit_count), 64'd0);
        chk("t5_fhb_cleared", 64'(bus16.first_hit_base), 64'hFFFF);
        bus16.total_len = 16'd5;
        bus16.start     = 1'b1;
        wait_done(0, 60, "t5_done");
        cyc(); cyc(); cyc();
        chk("t5_single_done", 64'(done_cnt16 - d0), 64'd1);
        chk("t5_q_empty", 64'(q16.size()), 64'd0);
        chk("t5_err_after", 64'(bus16.err_spurious), 64'd0);

        // T6: reset in the middle of a 2-group job, then rerun the same job.
        for (int g = 0; g < 2; g++) begin lat[1][g] = 5; hitcfg[1][g] = 1'b0; end
        push_chunks(1, 200, 0, 2);
        while (q2.size() > 2) void'(q2.pop_back());
        bus2.total_len = 16'd200;
        bus2.start     = 1'b1;
        d0 = done_cnt2;
        cyc(); cyc(); cyc(); cyc();
        chk("t6_busy_mid", 64'(bus2.busy), 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_rst2();
        chk("t6_q_empty", 64'(q2.size()), 64'd0);
        for (int i = 0; i < 8; i++) cyc();
        chk("t6_err_late_done", 64'(bus2.err_spurious), 64'd1);
        chk("t6_no_done", 64'(done_cnt2 - d0), 64'd0);
        chk("t6_busy_after", 64'(bus2.busy), 64'd0);
        run_t2("t6_rerun");
        chk("t6_err_cleared", 64'(bus2.err_spurious), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
